// File: rtl/gbuff_arb_if.sv
// rtl/gbuff_arb_if.sv - requester, response and SRAM command bundle for gbuff_arb
interface gbuff_arb_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_wen;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req1_valid;
  logic              req1_wen;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_data;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_di;
  logic [DATA_W-1:0] sram_do;

  // master: requesters plus the SRAM macro; slave: the arbiter
  modport master (
    output req0_valid, req0_wen, req0_addr, req0_wdata,
           req1_valid, req1_wen, req1_addr, req1_wdata,
           sram_do,
    input  req0_ready, req1_ready,
           rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
           sram_wen, sram_addr, sram_di
  );

  modport slave (
    input  req0_valid, req0_wen, req0_addr, req0_wdata,
           req1_valid, req1_wen, req1_addr, req1_wdata,
           sram_do,
    output req0_ready, req1_ready,
           rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
           sram_wen, sram_addr, sram_di
  );
endinterface

// File: rtl/gbuff_arb.sv
// rtl/gbuff_arb.sv - round-robin arbiter sharing one GBUFF SRAM between two requesters
// Optional grant/conflict statistics counters: define GBUFF_ARB_STATS_EN.
module gbuff_arb #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  gbuff_arb_if.slave  bus
`ifdef GBUFF_ARB_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1,
  output logic [15:0] conflict_cnt
`endif
);

  logic              ptr_q, ptr_d;
  logic              sram_wen_q, sram_wen_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_di_q, sram_di_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_id_q, s1_id_d;
  logic              s2_valid_q, s2_valid_d;
  logic              s2_id_q, s2_id_d;

  logic              gnt0;
  logic              gnt1;
  logic              gnt_any;
  logic              gnt_wen;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;

  // ptr names the requester that wins when both are valid
  always_comb begin
    gnt0      = bus.req0_valid && (!bus.req1_valid || !ptr_q);
    gnt1      = bus.req1_valid && (!bus.req0_valid || ptr_q);
    gnt_any   = gnt0 || gnt1;
    gnt_wen   = gnt1 ? bus.req1_wen   : bus.req0_wen;
    gnt_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
    gnt_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
  end

  always_comb begin
    ptr_d       = ptr_q;
    sram_wen_d  = 1'b0;
    sram_addr_d = sram_addr_q;
    sram_di_d   = sram_di_q;
    s1_valid_d  = 1'b0;
    s1_id_d     = s1_id_q;
    if (gnt_any) begin
      ptr_d       = !gnt1;
      sram_wen_d  = gnt_wen;
      sram_addr_d = gnt_addr;
      sram_di_d   = gnt_wdata;
      s1_valid_d  = !gnt_wen;
      s1_id_d     = gnt1;
    end
    // stage 2 lines up with the cycle sram_do carries the read word
    s2_valid_d = s1_valid_q;
    s2_id_d    = s1_id_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= 1'b0;
      sram_wen_q  <= 1'b0;
      sram_addr_q <= '0;
      sram_di_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_id_q     <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      sram_wen_q  <= sram_wen_d;
      sram_addr_q <= sram_addr_d;
      sram_di_q   <= sram_di_d;
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s2_valid_q  <= s2_valid_d;
      s2_id_q     <= s2_id_d;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp0_valid = s2_valid_q && !s2_id_q;
  assign bus.rsp1_valid = s2_valid_q && s2_id_q;
  assign bus.rsp0_data  = bus.sram_do;
  assign bus.rsp1_data  = bus.sram_do;
  assign bus.sram_wen   = sram_wen_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_di    = sram_di_q;

`ifdef GBUFF_ARB_STATS_EN
  logic [15:0] grant_cnt0_q, grant_cnt0_d;
  logic [15:0] grant_cnt1_q, grant_cnt1_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  // clear wins over a same-cycle increment
  always_comb begin
    grant_cnt0_d   = sat_inc(grant_cnt0_q, gnt0);
    grant_cnt1_d   = sat_inc(grant_cnt1_q, gnt1);
    conflict_cnt_d = sat_inc(conflict_cnt_q, bus.req0_valid && bus.req1_valid);
    if (stat_clr) begin
      grant_cnt0_d   = '0;
      grant_cnt1_d   = '0;
      conflict_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt0_q   <= '0;
      grant_cnt1_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant_cnt0_q   <= grant_cnt0_d;
      grant_cnt1_q   <= grant_cnt1_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign grant_cnt0   = grant_cnt0_q;
  assign grant_cnt1   = grant_cnt1_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_gbuff_arb.sv
// tb/tb_gbuff_arb.sv - scoreboard bench for gbuff_arb with a behavioural SRAM and reference model
module tb_gbuff_arb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gbuff_arb_if #(.ADDR_W(10), .DATA_W(32)) bus ();

`ifdef GBUFF_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;
  logic [15:0] conflict_cnt;
  logic [15:0] m_g0 = '0;
  logic [15:0] m_g1 = '0;
  logic [15:0] m_cf = '0;
`endif

  gbuff_arb #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef GBUFF_ARB_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1),
    .conflict_cnt (conflict_cnt)
`endif
  );

  typedef struct packed {
    logic        wen;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  req_t        q0[$];
  req_t        q1[$];
  exp_t        exp_q[$];
  logic        grant_log[$];
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_rsp0 = 0;
  int          n_rsp1 = 0;
  logic [31:0] last_rsp0 = '0;
  logic        mptr = 1'b0;
  logic        m_wen = 1'b0;
  logic [9:0]  m_addr = '0;
  logic [31:0] m_di = '0;
  logic [31:0] m_old = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.wen   = ($urandom_range(0, 2) == 0);
    r.addr  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
    r.wdata = $urandom;
    return r;
  endfunction

  // A write granted just before reset never commits: its command is cleared asynchronously.
  task automatic flush_model();
    if (m_wen) ref_mem[m_addr] = m_old;
    q0.delete();
    q1.delete();
    exp_q.delete();
    grant_log.delete();
    mptr   = 1'b0;
    m_wen  = 1'b0;
    m_addr = '0;
    m_di   = '0;
`ifdef GBUFF_ARB_STATS_EN
    m_g0 = '0;
    m_g1 = '0;
    m_cf = '0;
`endif
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size() + exp_q.size()) != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", 64'(q0.size() + q1.size() + exp_q.size()), 64'(0));
    repeat (2) @(posedge clk);
  endtask

  always @(posedge clk) cyc++;

  // SRAM macro: one access per cycle, read data valid the cycle after sampling
  always @(posedge clk) begin
    if (bus.sram_wen) mem[bus.sram_addr] = bus.sram_di;
    else bus.sram_do <= mem[bus.sram_addr];
  end

  always @(posedge clk) begin
    #1;
    if (rst && q0.size() > 0) begin
      bus.req0_valid = 1'b1;
      bus.req0_wen   = q0[0].wen;
      bus.req0_addr  = q0[0].addr;
      bus.req0_wdata = q0[0].wdata;
    end else begin
      bus.req0_valid = 1'b0;
    end
    if (rst && q1.size() > 0) begin
      bus.req1_valid = 1'b1;
      bus.req1_wen   = q1[0].wen;
      bus.req1_addr  = q1[0].addr;
      bus.req1_wdata = q1[0].wdata;
    end else begin
      bus.req1_valid = 1'b0;
    end
  end

  // Reference model: round-robin winner, SRAM command, memory image in grant order
  always @(negedge clk) begin : ref_model
    logic e0, e1, a0, a1;
    req_t r;
    if (rst) begin
      chk("sram_wen", 64'(bus.sram_wen), 64'(m_wen));
      chk("sram_addr", 64'(bus.sram_addr), 64'(m_addr));
      chk("sram_di", 64'(bus.sram_di), 64'(m_di));
      e0 = bus.req0_valid && (!bus.req1_valid || (mptr == 1'b0));
      e1 = bus.req1_valid && (!bus.req0_valid || (mptr == 1'b1));
      chk("req0_ready", 64'(bus.req0_ready), 64'(e0));
      chk("req1_ready", 64'(bus.req1_ready), 64'(e1));
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
`ifdef GBUFF_ARB_STATS_EN
      if (stat_clr) begin
        m_g0 = '0;
        m_g1 = '0;
        m_cf = '0;
      end else begin
        if (a0 && m_g0 != 16'hFFFF) m_g0++;
        if (a1 && m_g1 != 16'hFFFF) m_g1++;
        if (bus.req0_valid && bus.req1_valid && m_cf != 16'hFFFF) m_cf++;
      end
`endif
      m_wen = 1'b0;
      if (a0 || a1) begin
        r = a1 ? q1.pop_front() : q0.pop_front();
        grant_log.push_back(a1);
        mptr   = !a1;
        m_wen  = r.wen;
        m_addr = r.addr;
        m_di   = r.wdata;
        if (r.wen) begin
          m_old = ref_mem[r.addr];
          ref_mem[r.addr] = r.wdata;
        end else begin
          exp_q.push_back('{id: a1, data: ref_mem[r.addr], cyc: cyc + 2});
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (bus.rsp0_valid || bus.rsp1_valid)
        chk("rsp_in_reset", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'(0));
    end else if (bus.rsp0_valid || bus.rsp1_valid) begin
      if (bus.rsp0_valid) begin
        n_rsp0++;
        last_rsp0 = bus.rsp0_data;
      end
      if (bus.rsp1_valid) n_rsp1++;
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 64'({bus.rsp1_valid, bus.rsp0_valid}), e.id ? 64'(2) : 64'(1));
        chk("rsp_data", 64'(e.id ? bus.rsp1_data : bus.rsp0_data), 64'(e.data));
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      chk("rsp_missing", 64'(e.id ? bus.rsp1_valid : bus.rsp0_valid), 64'(1));
    end
  end

  initial begin : main
    logic [31:0] wd [4];
    int base0, base1, n;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'(i);
      ref_mem[i] = 32'(i);
    end
    bus.req0_valid = 1'b0;
    bus.req0_wen   = 1'b0;
    bus.req0_addr  = '0;
    bus.req0_wdata = '0;
    bus.req1_valid = 1'b0;
    bus.req1_wen   = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_wdata = '0;
    bus.sram_do    = '0;
    flush_model();
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;

    repeat (5) begin
      @(negedge clk);
      chk("idle_sram_addr", 64'(bus.sram_addr), 64'(0));
      chk("idle_rsp", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'(0));
      chk("idle_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'(0));
    end

    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom;
      q0.push_back('{1'b0, 10'(i), 32'h0});
      q1.push_back('{1'b1, 10'h100 + 10'(i), wd[i]});
    end
    drain();
    chk("contention_grants", 64'(grant_log.size()), 64'(8));
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk("contention_order", 64'(grant_log[i]), 64'(i % 2));
    for (int i = 0; i < 4; i++)
      chk("contention_mem", 64'(mem[10'h100 + 10'(i)]), 64'(wd[i]));

    base0 = n_rsp0;
    base1 = n_rsp1;
    @(posedge clk); #2;
    q0.push_back('{1'b0, 10'h005, 32'h0});
    drain();
    chk("solo_rsp0_count", 64'(n_rsp0 - base0), 64'(1));
    chk("solo_rsp0_data", 64'(last_rsp0), 64'(5));
    chk("solo_rsp1_count", 64'(n_rsp1 - base1), 64'(0));

    @(posedge clk); #2;
    q1.push_back('{1'b1, 10'h020, 32'hDEADBEEF});
    @(posedge clk); #2;
    q0.push_back('{1'b0, 10'h020, 32'h0});
    drain();
    chk("wr_then_rd_data", 64'(last_rsp0), 64'(32'hDEADBEEF));

    @(posedge clk); #2;
    q1.push_back('{1'b1, 10'h200, 32'h12345678});
    n = 0;
    while (q1.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("rst_wr_grant_timeout", 64'(q1.size()), 64'(0));
    #3;
    chk("sram_wen_before_rst", 64'(bus.sram_wen), 64'(1));
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    chk("sram_wen_async_clear", 64'(bus.sram_wen), 64'(0));
    flush_model();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    chk("rst_write_dropped", 64'(mem[10'h200]), 64'(32'h200));

    base0 = n_rsp0;
    @(posedge clk); #2;
    q0.push_back('{1'b0, 10'h007, 32'h0});
    n = 0;
    while (q0.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("rst_rd_grant_timeout", 64'(q0.size()), 64'(0));
    #3;
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    flush_model();
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    repeat (4) @(posedge clk);
    chk("rst_no_rsp", 64'(n_rsp0 - base0), 64'(0));
    #2;
    q0.push_back('{1'b0, 10'h001, 32'h0});
    q1.push_back('{1'b0, 10'h002, 32'h0});
    drain();
    chk("rst_first_grants", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() > 0) chk("rst_first_winner", 64'(grant_log[0]), 64'(0));

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      if (q0.size() < 2 && $urandom_range(0, 99) < 60) q0.push_back(rand_req());
      if (q1.size() < 2 && $urandom_range(0, 99) < 60) q1.push_back(rand_req());
    end
    drain();
    for (int i = 0; i < 16; i++)
      chk("final_mem", 64'(mem[i]), 64'(ref_mem[i]));

`ifdef GBUFF_ARB_STATS_EN
    @(posedge clk); #2 stat_clr = 1'b1;
    @(posedge clk); #2 stat_clr = 1'b0;
    for (int i = 0; i < 6; i++) q0.push_back('{1'b1, 10'h300 + 10'(i), $urandom});
    for (int i = 0; i < 5; i++) q1.push_back('{1'b1, 10'h380 + 10'(i), $urandom});
    drain();
    @(negedge clk);
    chk("stat_conflict", 64'(conflict_cnt), 64'(m_cf));
    chk("stat_grant0", 64'(grant_cnt0), 64'(m_g0));
    chk("stat_grant1", 64'(grant_cnt1), 64'(m_g1));
    @(posedge clk); #2 stat_clr = 1'b1;
    @(posedge clk); #2 stat_clr = 1'b0;
    @(negedge clk);
    chk("stat_clr_all", 64'({grant_cnt0, grant_cnt1, conflict_cnt}), 64'(0));
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk); #2;
      if (q0.size() < 2) q0.push_back('{1'b1, 10'h3FF, 32'(i)});
    end
    drain();
    @(negedge clk);
    chk("stat_grant0_sat", 64'(grant_cnt0), 64'(16'hFFFF));
    chk("stat_grant0_model", 64'(grant_cnt0), 64'(m_g0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gbuff_arb.md
# gbuff_arb

Two-requester arbiter that shares one single-port global buffer SRAM (same SRAM macro as GBUFF_A/GBUFF_B) between a pooling-input reader and a pooling-output writer. It grants at most one access per cycle with round-robin fairness and drives the SRAM command registers. It returns read data to the owning requester with a fixed latency. It sits between the pooling sequencer's read/write engines and a single GBUFF instance, so one buffer replaces two.

## Interface
- ADDR_W, 10, SRAM word-address width
- DATA_W, 32, SRAM word width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req0_valid / req1_valid  in  1  access request from requester 0 / 1
- req0_wen / req1_wen  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  ADDR_W  word address
- req0_wdata / req1_wdata  in  DATA_W  write data, ignored for reads
- req0_ready / req1_ready  out  1  grant; the access is accepted on the edge where valid && ready
- rsp0_valid / rsp1_valid  out  1  read data valid for requester 0 / 1
- rsp0_data / rsp1_data  out  DATA_W  read data, equals sram_do while the matching rsp valid is high
- sram_wen  out  1  SRAM write enable, registered
- sram_addr  out  ADDR_W  SRAM address, registered
- sram_di  out  DATA_W  SRAM write data, registered
- sram_do  in  DATA_W  SRAM read data, valid the cycle after the SRAM samples a read

## Operation
- Grant is combinational from valids and the round-robin pointer `ptr` (1 bit):
  - req0_ready = req0_valid && (!req1_valid || ptr==0)
  - req1_ready = req1_valid && (!req0_valid || ptr==1)
  - At most one ready per cycle. Ready is never asserted without valid.
- Pointer update on a grant edge: ptr <= ~granted_id, so the other requester has priority next cycle. No grant: ptr holds.
- On a grant edge: sram_wen <= granted wen, sram_addr <= granted addr, sram_di <= granted wdata.
- No grant: sram_wen <= 0; sram_addr and sram_di hold.
- Response pipeline, 2 stages, each holding {valid, id}:
  - Stage 1 loads {grant && !wen, granted_id}.
  - Stage 2 loads from stage 1.
  - rspN_valid = stage2.valid && stage2.id==N.
  - rspN_data = sram_do, combinational pass-through.
- Writes produce no response.
- Accesses reach the SRAM strictly in grant order. No forwarding and no reordering. A read granted after a write to the same address returns the written data.
- A requester holds valid, wen, addr and wdata stable until it sees ready. The arbiter does not check this.
- Reset values: ptr 0, sram_wen 0, sram_addr 0, sram_di 0, both stages invalid, so all rsp valids are 0.

## Timing
- Throughput: 1 access per cycle total. With both requesters continuously valid, grants alternate 0,1,0,1,…, starting with requester 0 after reset.
- Read latency:
  - Accept at edge k; sram_addr is valid during cycle k..k+1.
  - The SRAM samples at edge k+1.
  - rspN_valid is high for exactly one cycle between edge k+1 and edge k+2. The requester samples the data at edge k+2.
- Write: the SRAM commits at edge k+1.
- Back-to-back reads produce back-to-back responses in grant order. The responses may interleave between requesters.
- The response path has no backpressure. Requesters must always accept rsp.
- Reset asserted mid-operation: in-flight responses are dropped and no rsp valid is emitted afterwards. The SRAM command returns to idle (wen 0) immediately, asynchronously.
- Simultaneous new request and outstanding reads are independent. The pipeline never stalls.

## Configuration
- GBUFF_ARB_STATS_EN defined:
  - Adds ports stat_clr (in, 1), grant_cnt0 and grant_cnt1 (out, 16), and conflict_cnt (out, 16).
  - Each grant_cntN increments on every grant to requester N.
  - conflict_cnt increments on every cycle where both valids are high.
  - All counters saturate at 16'hFFFF.
  - stat_clr zeroes all counters synchronously and has priority over increment.
  - Reset value of all counters is 0.
- GBUFF_ARB_STATS_EN undefined: these ports and counters do not exist. Arbitration behaviour is identical.

## Test plan
- Reset, then idle: all ready/rsp 0, sram_wen 0, sram_addr 0 -> after rst release with no valid for 5 cycles, outputs unchanged.
- Solo read: req0 read addr 0x005 with SRAM preloaded 0x5 -> req0_ready the same cycle, sram_addr=0x005 next cycle, rsp0_valid one cycle later with rsp0_data=0x5, rsp1_valid stays 0.
- Contention: both valid continuously for 8 cycles, req0 reads addr 0..3 and req1 writes addr 0x100..0x103 -> grants 0,1,0,1,…; 4 rsp0 pulses carrying words 0..3; SRAM 0x100..0x103 written in order.
- Write-then-read ordering: req1 writes 0xDEADBEEF to 0x020, then req0 reads 0x020 the next cycle -> rsp0_data=0xDEADBEEF.
- Reset mid-flight: assert rst one cycle after a read grant -> no rsp pulse; after release, ptr=0 and req0 wins first contention.
- With GBUFF_ARB_STATS_EN: 10 contention cycles -> conflict_cnt=10, grant_cnt0=5, grant_cnt1=5; stat_clr for one cycle -> all 0; force 0x10000 grants -> grant_cnt0 stays 0xFFFF.
